cal1d_fp16_pool_acc: RTL and testbench

FP16-path 1D pooling window accumulator. It sits directly upstream of cal1d_fp16_pool_sum (4-lane fp17 adder array) and directly consumes its results.
- Takes a stream of 4-lane fp17 input beats.
- Per window, feeds {incoming beat, running partial} to the adder and captures the sum as the new partial.
- Emits one 4-lane sum per kernel-width beats to the downstream pool divide/output stage.

---
 rtl/cal1d_pool_pkg.sv | 16 +
 rtl/cal1d_fp16_pool_acc.sv | 175 +++++++++++++++++
 tb/tb_cal1d_fp16_pool_acc.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cal1d_pool_pkg.sv
// Shared types and constants for the FP16-path 1D pooling accumulator.
// fp17 lanes: sign[16], exp[15:10] (bias 31), mant[9:0].
package cal1d_pool_pkg;

    localparam int FP17_W = 17;
    localparam logic [FP17_W-1:0] FP17_ZERO = 17'h00000;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } pool_st_e;

endpackage

// File: rtl/cal1d_fp16_pool_acc.sv
// 1D pooling window accumulator: feeds {beat, partial} to an external adder.
// Optional: CAL1D_POOL_PERF_CNT_EN adds a saturating window counter output.
module cal1d_fp16_pool_acc #(
    parameter int LANES   = 4,
    parameter int DW      = cal1d_pool_pkg::FP17_W,
    parameter int KW_BITS = 3
) (
    input  logic                  nvdla_op_gated_clk_fp16,
    input  logic                  nvdla_core_rst,
    input  logic [KW_BITS-1:0]    cfg_kernel_width,
    input  logic                  pool_in_pvld,
    output logic                  pool_in_prdy,
    input  logic [LANES*DW-1:0]   pool_in_data,
    output logic                  sum_in_pvld,
    input  logic                  sum_in_prdy,
    output logic [DW-1:0]         sum_a_0,
    output logic [DW-1:0]         sum_a_1,
    output logic [DW-1:0]         sum_a_2,
    output logic [DW-1:0]         sum_a_3,
    output logic [DW-1:0]         sum_b_0,
    output logic [DW-1:0]         sum_b_1,
    output logic [DW-1:0]         sum_b_2,
    output logic [DW-1:0]         sum_b_3,
    input  logic                  sum_out_pvld,
    output logic                  sum_out_prdy,
    input  logic [DW-1:0]         sum_z_0,
    input  logic [DW-1:0]         sum_z_1,
    input  logic [DW-1:0]         sum_z_2,
    input  logic [DW-1:0]         sum_z_3,
`ifdef CAL1D_POOL_PERF_CNT_EN
    output logic [31:0]           perf_win_cnt,
`endif
    output logic                  pool_out_pvld,
    input  logic                  pool_out_prdy,
    output logic [LANES*DW-1:0]   pool_out_data
);

    import cal1d_pool_pkg::*;

    pool_st_e              r_state;
    pool_st_e              w_state_nxt;
    logic [LANES*DW-1:0]   r_partial;
    logic [LANES*DW-1:0]   w_partial_nxt;
    logic [3:0]            r_beat_cnt;
    logic [3:0]            w_beat_cnt_nxt;
    logic [KW_BITS-1:0]    r_kw_lat;
    logic [KW_BITS-1:0]    w_kw_lat_nxt;
    logic [LANES*DW-1:0]   w_sum_a;
    logic [LANES*DW-1:0]   w_sum_b;
    logic [LANES*DW-1:0]   w_sum_z;
    logic [DW-1:0]         w_a_lane [LANES];
    logic [DW-1:0]         w_b_lane [LANES];
    logic [DW-1:0]         w_z_lane [LANES];
    logic                  w_run;
    logic                  w_in_acc;
    logic                  w_out_acc;
    logic                  w_start;
    logic                  w_last;

    assign w_run = !nvdla_core_rst;

    // Stale or unexpected adder results are always drained.
    assign sum_out_prdy = 1'b1;

    assign w_z_lane[0] = sum_z_0;
    assign w_z_lane[1] = sum_z_1;
    assign w_z_lane[2] = sum_z_2;
    assign w_z_lane[3] = sum_z_3;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign w_a_lane[g]         = w_sum_a[DW*g +: DW];
            assign w_b_lane[g]         = w_sum_b[DW*g +: DW];
            assign w_sum_z[DW*g +: DW] = w_z_lane[g];
        end
    endgenerate

    assign sum_a_0 = w_a_lane[0];
    assign sum_a_1 = w_a_lane[1];
    assign sum_a_2 = w_a_lane[2];
    assign sum_a_3 = w_a_lane[3];
    assign sum_b_0 = w_b_lane[0];
    assign sum_b_1 = w_b_lane[1];
    assign sum_b_2 = w_b_lane[2];
    assign sum_b_3 = w_b_lane[3];

    assign w_in_acc  = pool_in_pvld & pool_in_prdy;
    assign w_out_acc = pool_out_pvld & pool_out_prdy;
    assign w_last    = (r_beat_cnt == (4'(r_kw_lat) + 4'd1));

    // Next-state, handshake and datapath selection for the window FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_partial_nxt  = r_partial;
        w_beat_cnt_nxt = r_beat_cnt;
        w_kw_lat_nxt   = r_kw_lat;
        pool_in_prdy   = 1'b0;
        sum_in_pvld    = 1'b0;
        pool_out_pvld  = 1'b0;
        pool_out_data  = '0;
        w_sum_a        = '0;
        w_sum_b        = '0;
        w_start        = 1'b0;
        unique case (r_state)
            IDLE: begin
                pool_in_prdy = w_run;
                w_start      = w_in_acc;
            end
            ISSUE: begin
                sum_in_pvld  = pool_in_pvld & w_run;
                pool_in_prdy = sum_in_prdy & w_run;
                w_sum_a      = pool_in_data;
                w_sum_b      = r_partial;
                if (w_in_acc) begin
                    w_beat_cnt_nxt = r_beat_cnt + 4'd1;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (sum_out_pvld) begin
                    w_partial_nxt = w_sum_z;
                    w_state_nxt   = w_last ? OUT : ISSUE;
                end
            end
            OUT: begin
                pool_out_pvld = w_run;
                pool_out_data = r_partial;
                pool_in_prdy  = pool_out_prdy & w_run;
                if (w_out_acc) begin
                    w_partial_nxt = '0;
                    w_state_nxt   = IDLE;
                    w_start       = w_in_acc;
                end
            end
        endcase
        if (w_start) begin
            w_partial_nxt  = pool_in_data;
            w_kw_lat_nxt   = cfg_kernel_width;
            w_beat_cnt_nxt = 4'd1;
            w_state_nxt    = (cfg_kernel_width == '0) ? OUT : ISSUE;
        end
    end

    // Window state, partial sum and beat bookkeeping registers.
    always_ff @(posedge nvdla_op_gated_clk_fp16) begin
        if (nvdla_core_rst) begin
            r_state    <= IDLE;
            r_partial  <= {LANES{FP17_ZERO}};
            r_beat_cnt <= 4'd0;
            r_kw_lat   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_partial  <= w_partial_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_kw_lat   <= w_kw_lat_nxt;
        end
    end

`ifdef CAL1D_POOL_PERF_CNT_EN
    logic [31:0] r_perf_cnt;

    // Saturating count of emitted windows.
    always_ff @(posedge nvdla_op_gated_clk_fp16) begin
        if (nvdla_core_rst) begin
            r_perf_cnt <= 32'd0;
        end else if (w_out_acc && (r_perf_cnt != 32'hFFFF_FFFF)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_win_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_cal1d_fp16_pool_acc.sv
// Directed and randomized bench for cal1d_fp16_pool_acc with a model adder.
// Inputs driven on negedge, handshakes evaluated 1ns later.
module tb_cal1d_fp16_pool_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cfg;
    logic        in_pvld;
    logic        in_prdy;
    logic [67:0] in_data;
    logic        sum_in_pvld;
    logic        sum_in_prdy;
    logic [16:0] a0, a1, a2, a3;
    logic [16:0] b0, b1, b2, b3;
    logic        sum_out_pvld;
    logic        sum_out_prdy;
    logic [16:0] z0, z1, z2, z3;
    logic        out_pvld;
    logic        out_prdy;
    logic [67:0] out_data;
`ifdef CAL1D_POOL_PERF_CNT_EN
    logic [31:0] perf;
`endif

    always #5 clk = ~clk;

    cal1d_fp16_pool_acc u_dut (
        .nvdla_op_gated_clk_fp16 (clk),
        .nvdla_core_rst          (rst),
        .cfg_kernel_width        (cfg),
        .pool_in_pvld            (in_pvld),
        .pool_in_prdy            (in_prdy),
        .pool_in_data            (in_data),
        .sum_in_pvld             (sum_in_pvld),
        .sum_in_prdy             (sum_in_prdy),
        .sum_a_0                 (a0),
        .sum_a_1                 (a1),
        .sum_a_2                 (a2),
        .sum_a_3                 (a3),
        .sum_b_0                 (b0),
        .sum_b_1                 (b1),
        .sum_b_2                 (b2),
        .sum_b_3                 (b3),
        .sum_out_pvld            (sum_out_pvld),
        .sum_out_prdy            (sum_out_prdy),
        .sum_z_0                 (z0),
        .sum_z_1                 (z1),
        .sum_z_2                 (z2),
        .sum_z_3                 (z3),
`ifdef CAL1D_POOL_PERF_CNT_EN
        .perf_win_cnt            (perf),
`endif
        .pool_out_pvld           (out_pvld),
        .pool_out_prdy           (out_prdy),
        .pool_out_data           (out_data)
    );

    typedef struct {
        logic [67:0] d;
        logic [2:0]  cfg;
    } beat_t;

    beat_t       in_q [$];
    logic [67:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int in_pct = 100;
    int ar_pct = 100;
    int out_pct = 100;
    int lat_lo = 3;
    int lat_hi = 3;
    int txn = 0;
    int seen_req = 0;
    int n_extra = 0;
    int n_out = 0;
    int acc_cyc = 0;
    int out_cyc = 0;
    bit busy = 0;
    bit in_taken = 0;
    int lat_cnt = 0;
    logic [67:0] res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [67:0] got,
                       input logic [67:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] i2f(input int n);
        int p;
        logic [16:0] r;
        if (n == 0) return 17'h0;
        p = 0;
        for (int i = 0; i < 16; i++)
            if ((n >> i) != 0) p = i;
        r = '0;
        r[15:10] = 6'(31 + p);
        r[9:0]   = 10'((n << 10) >> p);
        return r;
    endfunction

    function automatic int f2i(input logic [16:0] x);
        int e;
        int m;
        if (x == 17'h0) return 0;
        e = int'(x[15:10]) - 31;
        m = int'({1'b1, x[9:0]});
        return m >> (10 - e);
    endfunction

    function automatic logic [67:0] rep(input logic [16:0] v);
        return {4{v}};
    endfunction

    task automatic push(input logic [67:0] d, input logic [2:0] c);
        beat_t b;
        b.d = d;
        b.cfg = c;
        in_q.push_back(b);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({tag, "_drain"}, 68'(in_q.size() + exp_q.size()), 68'd0);
    endtask

    // input beat driver
    initial begin
        in_pvld = 1'b0;
        in_data = '0;
        cfg = '0;
        forever begin
            @(negedge clk);
            if (in_taken) begin
                in_pvld = 1'b0;
                in_taken = 0;
            end
            if (!in_pvld && in_q.size() > 0 && $urandom_range(99) < in_pct) begin
                in_pvld = 1'b1;
                in_data = in_q[0].d;
                cfg = in_q[0].cfg;
            end
            #1;
            if (in_pvld && in_prdy) begin
                acc_cyc = cyc;
                void'(in_q.pop_front());
                in_taken = 1;
            end
        end
    end

    // model adder, one transaction in flight
    initial begin
        logic [67:0] av;
        logic [67:0] bv;
        sum_in_prdy = 1'b0;
        sum_out_pvld = 1'b0;
        {z3, z2, z1, z0} = '0;
        forever begin
            @(negedge clk);
            if (busy && lat_cnt > 0) lat_cnt--;
            sum_out_pvld = busy && (lat_cnt == 0);
            {z3, z2, z1, z0} = sum_out_pvld ? res : 68'd0;
            sum_in_prdy = !busy && ($urandom_range(99) < ar_pct);
            #1;
            if (sum_in_pvld) seen_req = 1;
            if (sum_out_pvld && sum_out_prdy) busy = 0;
            if (sum_in_pvld && sum_in_prdy) begin
                txn++;
                busy = 1;
                lat_cnt = $urandom_range(lat_hi, lat_lo);
                av = {a3, a2, a1, a0};
                bv = {b3, b2, b1, b0};
                for (int l = 0; l < 4; l++)
                    res[17*l +: 17] = i2f(f2i(av[17*l +: 17]) + f2i(bv[17*l +: 17]));
            end
        end
    end

    // window sum sink and scoreboard
    initial begin
        out_prdy = 1'b0;
        forever begin
            @(negedge clk);
            out_prdy = ($urandom_range(99) < out_pct);
            #1;
            if (out_pvld && out_prdy) begin
                n_out++;
                out_cyc = cyc;
                if (exp_q.size() > 0) chk("win_sum", out_data, exp_q.pop_front());
                else n_extra++;
            end
        end
    end

    initial begin
        int n;
        int exp_txn;
        int out0;
        logic [67:0] d;
        logic [67:0] s;
        int kw;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_hs", 68'({sum_in_pvld, out_pvld, in_prdy, sum_out_prdy}), 68'b0001);
        chk("rst_out_data", out_data, 68'd0);
        chk("rst_sum_a", {a3, a2, a1, a0}, 68'd0);
        chk("rst_sum_b", {b3, b2, b1, b0}, 68'd0);
        @(negedge clk);
        rst = 1'b0;

        // width-1 window
        txn = 0;
        seen_req = 0;
        push(rep(17'h07C00), 3'd0);
        exp_q.push_back(rep(17'h07C00));
        drain("kw0", 50);
        chk("kw0_lat", 68'(out_cyc - acc_cyc), 68'd1);
        chk("kw0_noreq", 68'(seen_req), 68'd0);

        // three beats of 1.0
        txn = 0;
        for (int i = 0; i < 3; i++) push(rep(17'h07C00), 3'd2);
        exp_q.push_back(rep(17'h08200));
        drain("kw2", 100);
        chk("kw2_txn", 68'(txn), 68'd2);

        // four beats with output back-pressure
        out_pct = 0;
        push(rep(17'h07C00), 3'd3);
        push(rep(17'h07C00), 3'd3);
        push(rep(17'h08000), 3'd3);
        push(rep(17'h00000), 3'd3);
        exp_q.push_back(rep(17'h08400));
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            #1;
            if (out_pvld) break;
            n++;
        end
        chk("hold_seen", 68'(out_pvld), 68'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("hold_pvld", 68'(out_pvld), 68'd1);
            chk("hold_data", out_data, rep(17'h08400));
        end
        out_pct = 100;
        drain("kw3", 100);

        // kernel width change after first beat is ignored
        txn = 0;
        push(rep(17'h07C00), 3'd2);
        push(rep(17'h07C00), 3'd0);
        push(rep(17'h07C00), 3'd0);
        push(rep(17'h08000), 3'd0);
        exp_q.push_back(rep(17'h08200));
        exp_q.push_back(rep(17'h08000));
        drain("cfgchg", 100);
        chk("cfgchg_txn", 68'(txn), 68'd2);

        // reset while waiting on the adder
        push(rep(17'h07C00), 3'd1);
        push(rep(17'h07C00), 3'd1);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            #1;
            if (busy) break;
            n++;
        end
        chk("rw_busy", 68'(busy), 68'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_hs", 68'({sum_in_pvld, out_pvld, in_prdy, sum_out_prdy}), 68'b0001);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw_idle_prdy", 68'(in_prdy), 68'd1);
        chk("rw_no_out", 68'(out_pvld), 68'd0);
        push(rep(17'h07C00), 3'd1);
        push(rep(17'h07C00), 3'd1);
        exp_q.push_back(rep(17'h08000));
        drain("rw", 100);
        chk("rw_extra", 68'(n_extra), 68'd0);

        // random windows under back-pressure everywhere
        in_pct = 70;
        ar_pct = 70;
        out_pct = 70;
        lat_lo = 0;
        lat_hi = 2;
        txn = 0;
        exp_txn = 0;
        out0 = n_out;
        for (int w = 0; w < 1000; w++) begin
            kw = $urandom_range(7);
            exp_txn += kw;
            s = '0;
            for (int b = 0; b <= kw; b++) begin
                for (int l = 0; l < 4; l++) begin
                    n = $urandom_range(15);
                    d[17*l +: 17] = i2f(n);
                    s[17*l +: 17] = i2f(f2i(s[17*l +: 17]) + n);
                end
                push(d, (b == 0) ? 3'(kw) : 3'($urandom_range(7)));
            end
            exp_q.push_back(s);
        end
        drain("rand", 90000);
        chk("rand_txn", 68'(txn), 68'(exp_txn));
        chk("rand_nout", 68'(n_out - out0), 68'd1000);
        chk("rand_extra", 68'(n_extra), 68'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
